// File: rtl/rf_pkg.sv
// Shared register-file writeback types and widths for the writeback arbiter slice.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = {REG_ADDR_W{1'b0}};

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Register 0 is hardwired, so writes and pending marks to it are meaningless.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] a);
    return a != ZERO_ADDR;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular buffer holding long-latency results until the RF write port is free.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    push_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{addr: ZERO_ADDR, data: {DATA_W{1'b0}}};
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB beats buffered long-latency results,
// with a pending scoreboard. Starvation stall is built only when RF_WB_STARVE_EN is defined.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_wr,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  lu_valid,
  input  logic [REG_ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  lu_ready,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  hazard_stall,
  output logic                  pipe_stall,
  output logic                  rf_wr,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic             lu_ready_r;
  logic [31:0]      pending_r;
  logic [31:0]      pending_nxt_s;
  logic             wb_eff_s;
  logic             push_s;
  logic             fifo_grant_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  wb_entry_t        fifo_head_s;
  wb_entry_t        push_entry_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             rf_wr_s;
  logic [REG_ADDR_W-1:0] rf_addr_s;
  logic [DATA_W-1:0]     rf_data_s;

  assign wb_eff_s     = wb_wr && is_real_reg(wb_addr);
  // Zero-address results still complete the handshake; they are simply not buffered.
  assign push_s       = lu_valid && lu_ready_r && is_real_reg(lu_addr) && !fifo_full_s;
  assign fifo_grant_s = !wb_eff_s && !fifo_empty_s;
  assign push_entry_s = '{addr: lu_addr, data: lu_data};

  rf_wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (fifo_grant_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s)
  );

  // Write-port mux: pipeline writeback first, then buffered head.
  always_comb begin
    rf_wr_s   = 1'b0;
    rf_addr_s = ZERO_ADDR;
    rf_data_s = {DATA_W{1'b0}};
    if (wb_eff_s) begin
      rf_wr_s   = 1'b1;
      rf_addr_s = wb_addr;
      rf_data_s = wb_data;
    end else if (fifo_grant_s) begin
      rf_wr_s   = 1'b1;
      rf_addr_s = fifo_head_s.addr;
      rf_data_s = fifo_head_s.data;
    end else begin
      rf_wr_s   = 1'b0;
    end
  end

  assign rf_wr   = rf_wr_s;
  assign rf_addr = rf_addr_s;
  assign rf_data = rf_data_s;

  // Post-edge occupancy, so lu_ready tracks "not full" without a pop-to-push bypass.
  always_comb begin
    count_nxt_s = fifo_count_s;
    if (push_s) begin
      count_nxt_s = count_nxt_s + CNT_W'(1);
    end else begin
      count_nxt_s = count_nxt_s;
    end
    if (fifo_grant_s) begin
      count_nxt_s = count_nxt_s - CNT_W'(1);
    end else begin
      count_nxt_s = count_nxt_s;
    end
  end

  // Registered ready; low throughout reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lu_ready_r <= 1'b0;
    end else begin
      lu_ready_r <= (count_nxt_s != DEPTH_C);
    end
  end

  assign lu_ready = lu_ready_r;

  // Scoreboard update: clear on buffered write, then a same-address issue re-sets it.
  always_comb begin
    pending_nxt_s = pending_r;
    if (fifo_grant_s) begin
      pending_nxt_s[fifo_head_s.addr] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (issue_valid && is_real_reg(issue_addr)) begin
      pending_nxt_s[issue_addr] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Pending-destination register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= 32'h0000_0000;
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign hazard_stall = pending_r[rd_addr1] | pending_r[rd_addr2];

`ifdef RF_WB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_r;
  logic [SC_W-1:0] starve_nxt_s;
  logic            pipe_stall_r;

  // Count consecutive cycles the buffered head loses arbitration, saturating.
  always_comb begin
    starve_nxt_s = starve_r;
    if (fifo_empty_s || fifo_grant_s) begin
      starve_nxt_s = {SC_W{1'b0}};
    end else if (starve_r != LIMIT_C) begin
      starve_nxt_s = starve_r + SC_W'(1);
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Starvation counter and the registered stall request it drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_r     <= {SC_W{1'b0}};
      pipe_stall_r <= 1'b0;
    end else begin
      starve_r     <= starve_nxt_s;
      pipe_stall_r <= (starve_nxt_s == LIMIT_C);
    end
  end

  assign pipe_stall = pipe_stall_r;
`else
  assign pipe_stall = 1'b0;
`endif

endmodule
